// File: rtl/fmap_loader_if.sv
// Stream-in / frame-out bundle of the feature-map loader.
// The loader takes the slave view; a producer/consumer or bench takes the master view.
interface fmap_loader_if #(
  parameter int in_width = 3,
  parameter int pad      = 1,
  parameter int DATA_W   = 32
);
  localparam int out_width = in_width + 2*pad;

  logic                                  s_valid;
  logic                                  s_ready;
  logic signed [DATA_W-1:0]              s_data;
  logic                                  s_last;
  logic [out_width*out_width*DATA_W-1:0] out_map;
  logic                                  map_valid;
  logic                                  map_ack;
  logic                                  frame_err;

  modport slave (
    input  s_valid, s_data, s_last, map_ack,
    output s_ready, out_map, map_valid, frame_err
  );

  modport master (
    output s_valid, s_data, s_last, map_ack,
    input  s_ready, out_map, map_valid, frame_err
  );
endinterface

// File: rtl/fmap_loader.sv
// Stream-to-frame loader: row-major pixels fill the interior of a zero-padded
// feature map, published as one flat vector until the consumer acks it.
module fmap_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     word_q <= '0;
    else if (clr_i) word_q <= '0;
    else if (we_i)  word_q <= d_i;
  end

  assign q_o = word_q;
endmodule

module fmap_loader #(
  parameter int in_width = 3,
  parameter int pad      = 1,
  parameter int DATA_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fmap_loader_if.slave bus
);
  localparam int out_width = in_width + 2*pad;
  localparam int NPIX      = in_width * in_width;
  localparam int MAP_W     = out_width * out_width * DATA_W;
  localparam int CW        = (in_width > 1) ? $clog2(in_width) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(in_width - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               row_q, row_d, col_q, col_d;
  logic                        err_q, err_d;
  logic                        accept, last_pix, clr;
  logic [NPIX-1:0]             we;
  logic [DATA_W-1:0]           din;
  logic [NPIX-1:0][DATA_W-1:0] pix;
  logic [MAP_W-1:0]            map;

  assign accept   = bus.s_valid && (state_q == FILL);
  assign last_pix = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign din      = bus.s_data;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      FILL: if (accept) begin
        if (last_pix) begin
          // Frame is published even when s_last is missing; the error only flags it.
          state_d = HOLD;
          err_d   = !bus.s_last;
          row_d   = '0;
          col_d   = '0;
        end else if (bus.s_last) begin
          err_d = 1'b1;
          clr   = 1'b1;
          row_d = '0;
          col_d = '0;
        end else if (col_q == LAST_IDX) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      HOLD: if (bus.map_ack) begin
        state_d = FILL;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  // One-hot write select straight from the row/column counters.
  always_comb begin
    we = '0;
    for (int r = 0; r < in_width; r++)
      for (int c = 0; c < in_width; c++)
        we[r*in_width + c] = accept && !clr && (row_q == CW'(r)) && (col_q == CW'(c));
  end

  fmap_cell #(.DATA_W(DATA_W)) u_cell [NPIX-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (we),
    .clr_i (clr),
    .d_i   (din),
    .q_o   (pix)
  );

  // Border words are hard zero; only interior words have storage behind them.
  always_comb begin
    map = '0;
    for (int r = 0; r < in_width; r++)
      for (int c = 0; c < in_width; c++)
        map[((r + pad)*out_width + c + pad)*DATA_W +: DATA_W] = pix[r*in_width + c];
  end

  assign bus.out_map   = map;
  assign bus.s_ready   = (state_q == FILL);
  assign bus.map_valid = (state_q == HOLD);
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_fmap_loader.sv
// Scoreboard bench for fmap_loader: the driver queues expected publish/error
// events, a negedge monitor pops and checks them as the DUT presents them.
module tb_fmap_loader;
  localparam int MAPW = 25 * 32;

  typedef int frame_t [9];
  typedef struct {
    bit              mv;
    bit              err;
    logic [MAPW-1:0] map;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q [$];

  // Hand-computed flat word indices of the 3x3 interior in the 5x5 frame.
  int interior [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  frame_t F1 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  frame_t FN = '{-1, -2, -3, -4, -5, -6, -7, -8, -9};
  frame_t FX = '{100, 101, 102, 103, 104, 105, 106, 107, 108};

  fmap_loader_if #(.in_width(3), .pad(1), .DATA_W(32)) bus ();

  fmap_loader #(.in_width(3), .pad(1), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [MAPW-1:0] act, input logic [MAPW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [MAPW-1:0] mk_map(input frame_t px);
    logic [MAPW-1:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) m[interior[i]*32 +: 32] = px[i];
    return m;
  endfunction

  function automatic int word(input int idx);
    return int'(bus.out_map[idx*32 +: 32]);
  endfunction

  task automatic expect_ev(input bit mv, input bit err, input logic [MAPW-1:0] m);
    exp_t e;
    e.mv = mv; e.err = err; e.map = m; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic send_px(input int d, input logic last);
    int t;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    t = 0;
    while (!bus.s_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.s_ready) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: s_ready stuck at %0b want 1", bus.s_ready);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic send_frame(input frame_t px, input int n, input int last_idx,
                            input bit bub, input bit ack_fill);
    for (int i = 0; i < n; i++) begin
      if (bub) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      if (ack_fill) bus.map_ack = (i < n - 1);
      send_px(px[i], i == last_idx);
    end
    bus.map_ack = 1'b0;
  endtask

  task automatic ack();
    bus.map_ack = 1'b1;
    @(posedge clk); #1;
    bus.map_ack = 1'b0;
  endtask

  // Monitor: every map_valid rise or frame_err pulse must match the next queued event.
  initial begin
    exp_t e;
    logic mv_prev;
    mv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ((bus.map_valid && !mv_prev) || bus.frame_err)) begin
        if (q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_event: map_valid=%0b frame_err=%0b with empty queue",
                   bus.map_valid, bus.frame_err);
        end else begin
          e = q.pop_front();
          chki("ev_map_valid", 32'(bus.map_valid), 32'(e.mv));
          chki("ev_frame_err", 32'(bus.frame_err), 32'(e.err));
          chki("ev_latency", cyc, e.cyc);
          chk("ev_out_map", bus.out_map, e.map);
        end
      end
      mv_prev = bus.map_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.map_ack = 1'b0;

    // Async reset mid-clock, checked before any edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_map", bus.out_map, '0);
    chki("rst_s_ready", 32'(bus.s_ready), 1);
    chki("rst_map_valid", 32'(bus.map_valid), 0);
    chki("rst_frame_err", 32'(bus.frame_err), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Full-rate frame.
    send_frame(F1, 9, 8, 1'b0, 1'b0);
    expect_ev(1'b1, 1'b0, mk_map(F1));
    chki("full_w6", word(6), 1);
    chki("full_w8", word(8), 3);
    chki("full_w12", word(12), 5);
    chki("full_w18", word(18), 9);
    chki("full_w0", word(0), 0);
    chki("full_w14", word(14), 0);
    chki("full_w24", word(24), 0);

    // Backpressure while holding the frame.
    bus.s_valid = 1'b1; bus.s_data = 99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chki("hold_s_ready", 32'(bus.s_ready), 0);
      chki("hold_map_valid", 32'(bus.map_valid), 1);
      chk("hold_out_map", bus.out_map, mk_map(F1));
    end
    bus.s_valid = 1'b0;
    ack();
    chki("ack_map_valid", 32'(bus.map_valid), 0);
    chki("ack_s_ready", 32'(bus.s_ready), 1);

    // Negative pixels keep full width and sign.
    send_frame(FN, 9, 8, 1'b0, 1'b0);
    expect_ev(1'b1, 1'b0, mk_map(FN));
    chki("neg_w6", word(6), 32'hFFFFFFFF);
    chki("neg_w18", word(18), 32'hFFFFFFF7);
    ack();

    // Bubbles, with map_ack held high during fill (must be ignored).
    send_frame(F1, 9, 8, 1'b1, 1'b1);
    expect_ev(1'b1, 1'b0, mk_map(F1));
    ack();

    // Early s_last on 4th pixel discards the partial frame.
    send_frame(F1, 4, 3, 1'b0, 1'b0);
    expect_ev(1'b0, 1'b1, '0);
    @(posedge clk); #1;
    chki("early_err_1cyc", 32'(bus.frame_err), 0);
    chki("early_no_valid", 32'(bus.map_valid), 0);
    chk("early_cleared", bus.out_map, '0);
    send_frame(F1, 9, 8, 1'b0, 1'b0);
    expect_ev(1'b1, 1'b0, mk_map(F1));
    ack();

    // Missing s_last: error and publish in the same cycle.
    send_frame(FX, 9, -1, 1'b0, 1'b0);
    expect_ev(1'b1, 1'b1, mk_map(FX));
    @(posedge clk); #1;
    chki("nolast_err_1cyc", 32'(bus.frame_err), 0);
    ack();

    // Reset after 5 pixels.
    send_frame(F1, 5, -1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_map", bus.out_map, '0);
    chki("midrst_frame_err", 32'(bus.frame_err), 0);
    chki("midrst_s_ready", 32'(bus.s_ready), 1);
    chki("midrst_map_valid", 32'(bus.map_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_frame(F1, 9, 8, 1'b0, 1'b0);
    expect_ev(1'b1, 1'b0, mk_map(F1));
    chki("post_rst_w6", word(6), 1);
    ack();

    repeat (3) @(posedge clk);
    #1;
    chki("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/fmap_loader.md
# fmap_loader

Stream-to-frame loader that writes incoming 32-bit signed pixels, one per handshake, into a zero-padded feature-map register. It publishes the frame as a flat packed vector in the same layout the pooling and activation stages consume from the memory block. It is the writer side of the frame interface: a live producer, such as an upstream layer or host link, fills it instead of an init file. Padding positions are never written and always read zero.

## Interface

Parameters:
- in_width, 3: unpadded image side length; frame holds in_width*in_width pixels
- pad, 1: zero border width on each side
- out_width (localparam): in_width + 2*pad
- DATA_W, 32: pixel width, signed two's complement

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous and active-low
- s_valid  in  1  producer has a pixel on s_data
- s_ready  out  1  loader can accept a pixel
- s_data  in  DATA_W  signed pixel, row-major order of the unpadded image
- s_last  in  1  marks the final pixel of a frame; sampled only on acceptance
- out_map  out  out_width*out_width*DATA_W  packed padded frame; element (r,c) at bits [(r*out_width+c)*DATA_W +: DATA_W]
- map_valid  out  1  out_map holds a complete frame
- map_ack  in  1  consumer has taken the frame; sampled only while map_valid=1
- frame_err  out  1  one-cycle pulse on a framing error

## Operation

- Two states, registered:
  - FILL: s_ready=1, map_valid=0.
  - HOLD: s_ready=0, map_valid=1.
- Acceptance occurs when s_valid & s_ready.
- Accepted pixel i (0-based counter) is written to r = pad + i/in_width, c = pad + i%in_width.
  - Row and column counters are used; no divider.
  - Width is preserved: no saturation and no sign change.
- FILL → HOLD on acceptance of pixel N-1, where N = in_width*in_width. The transition happens regardless of s_last.
  - If s_last=0 on pixel N-1: frame_err pulses, and the frame is still published.
- Early s_last (accepted with i < N-1):
  - frame_err pulses.
  - The partial frame is discarded: all interior words are cleared to 0 and counters reset to 0.
  - State stays FILL.
- HOLD → FILL on map_ack=1. Counters reset to 0.
  - out_map keeps the previous frame contents until they are overwritten pixel by pixel.
- map_ack while in FILL is ignored.
- Border words (r<pad, r>=pad+in_width, c<pad, c>=pad+in_width) are constant 0. They are never written.

## Timing

- Reset (async assert, sync-to-clk release):
  - state=FILL, s_ready=1, map_valid=0, frame_err=0.
  - out_map all zero; counters 0.
- Write latency: a pixel accepted at edge T is visible in out_map after edge T.
- Final pixel accepted at edge T:
  - map_valid=1 and s_ready=0 from T until the ack edge.
  - out_map is complete in the same cycle that map_valid rises.
- map_ack high at edge A (with map_valid=1): map_valid=0 and s_ready=1 after A. The earliest next acceptance is at edge A+1.
- Frame period at full rate: N accept cycles + 1 cycle minimum in HOLD.
- frame_err is high for exactly the one cycle after the offending acceptance edge.
  - Missing-last case: this cycle coincides with the first map_valid cycle.
- s_ready depends only on state (registered). There is no combinational path from s_valid or map_ack to s_ready.
- s_valid may drop between pixels. Bubbles have no effect on content.
- Reset asserted mid-frame:
  - The partial frame is lost.
  - Outputs return to reset values immediately.
  - No frame_err is generated.

## Test plan

Defaults used in every scenario: in_width=3, pad=1, so out_width=5 and out_map is 25 words (800 bits).

- **Reset:** assert rst_n=0 mid-clock → out_map==0, s_ready=1, map_valid=0, frame_err=0 without waiting for an edge.
- **Full-rate frame:** pixels 1..9 back-to-back, s_last on 9 →
  - map_valid=1 the cycle after the 9th acceptance.
  - word 6=1, word 8=3, word 12=5, word 18=9.
  - words 0–5, 9, 10, 14, 15, 19–24 = 0.
  - frame_err=0.
- **Backpressure and ack:** hold map_ack=0 for 10 cycles while s_valid=1, s_data=99 →
  - s_ready=0 and out_map unchanged throughout.
  - Pulse map_ack → next cycle map_valid=0, s_ready=1.
  - The following frame of pixels -1..-9 gives word 6=32'hFFFFFFFF and word 18=32'hFFFFFFF7.
- **Bubbles:** same 1..9 frame with s_valid toggling randomly (about 50%) → identical out_map to the full-rate frame; map_valid one cycle after the 9th acceptance.
- **Framing errors:**
  - s_last on the 4th pixel → 1-cycle frame_err, no map_valid, interior words all 0. A following clean 1..9 frame publishes correctly.
  - A frame of 9 pixels with no s_last → frame_err and map_valid rise in the same cycle.
- **Reset mid-frame:** reset after 5 pixels accepted → out_map==0, no frame_err. A following full frame publishes correctly, with pixel 1 at word 6.
